// File: rtl/arith_pkg.sv
// Shared arithmetic types: serial-adder FSM states and counter sizing helper.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit-counter width that holds 0..WIDTH-1 with headroom so it never wraps in a run.
   function automatic int unsigned cnt_width(input int unsigned w);
      return int'($clog2(w)) + 1;
   endfunction

endpackage : arith_pkg

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry of one bit position.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
   end

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, parallel load/unload.
module serial_adder
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] opa_q,    opa_d;
   logic [WIDTH-1:0] opb_q,    opb_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             carry_q,  carry_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             cout_q,   cout_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_sr_next;

   full_adder_cell u_fa (
      .a  (opa_q[0]),
      .b  (opb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Shift the new sum bit in at the MSB so the LSB lands at bit 0 after WIDTH steps.
   always_comb begin
      sum_sr_next = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cout_d   = cout_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               opa_d    = a;
               opb_d    = b;
               carry_d  = cin;
               sum_sr_d = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            opa_d    = opa_q >> 1;
            opb_d    = opb_q >> 1;
            sum_sr_d = sum_sr_next;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = sum_sr_next;
               cout_d  = fa_co;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_adder
